// File: rtl/loader_pkg.sv
// Shared types and default constants for the debug memory loader.
// Provides the FSM state enum, cache target enum and default header bytes.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        DATA,
        WRITE,
        VERIFY,
        TAIL
    } state_e;

    typedef enum logic {
        TGT_INST,
        TGT_DATA
    } target_e;

    localparam logic [7:0] DEF_HDR_INST       = 8'hA5;
    localparam logic [7:0] DEF_HDR_DATA       = 8'h5A;
    localparam int         DEF_RELEASE_CYCLES = 4;
    localparam int         DEF_RD_LAT         = 1;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// Ports: clk, rst (sync, high), clear (idx->0), byte_en/byte_in (shift in),
//        word (registered), word_next (word incl. current byte), idx, word_valid (4th byte now).
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic [1:0]  idx,
    output logic        word_valid
);

    // Bytes enter at the top so the first byte ends up as the LSB.
    assign word_next  = {byte_in, word[31:8]};
    assign word_valid = byte_en && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= '0;
        end else begin
            if (byte_en) begin
                word <= word_next;
            end
            if (clear) begin
                idx <= '0;
            end else if (byte_en) begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/debug_mem_loader.sv
// Host byte-stream loader writing words into the core's inst/data caches via the debug port.
// Ports: clk, rst (sync, high), rx_data/rx_valid/rx_ready byte handshake,
//        ic_a2/ic_wd2/ic_we2/ic_rd2 and dc_a2/dc_wd2/dc_we2/dc_rd2 debug ports,
//        cpu_rst (core reset), busy (frame active), done (tail expired pulse), err (sticky).
// Option: define LOADER_VERIFY_EN to read back each written word and flag mismatches.
module debug_mem_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] HDR_INST       = DEF_HDR_INST,
    parameter logic [7:0] HDR_DATA       = DEF_HDR_DATA,
    parameter int         RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter int         RD_LAT         = DEF_RD_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] ic_a2,
    output logic [31:0] ic_wd2,
    output logic [3:0]  ic_we2,
    input  logic [31:0] ic_rd2,
    output logic [31:0] dc_a2,
    output logic [31:0] dc_wd2,
    output logic [3:0]  dc_we2,
    input  logic [31:0] dc_rd2,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state, state_d;
    target_e     tgt;
    logic [31:0] addr;
    logic [15:0] remaining;
    logic [7:0]  tail_cnt;

    logic        acc;
    logic        is_hdr;
    logic        pk_en;
    logic        pk_clr;
    logic        pk_valid;
    logic [1:0]  pk_idx;
    logic [31:0] pk_word;
    logic [31:0] pk_next;
    logic        cnt_last;
    logic        last_word;
    logic        tail_end;
    logic        wr_strobe;
    logic        port_on;

    assign rx_ready  = (state == IDLE) || (state == ADDR) ||
                       (state == CNT)  || (state == DATA);
    assign acc       = rx_valid && rx_ready;
    assign is_hdr    = (rx_data == HDR_INST) || (rx_data == HDR_DATA);
    assign pk_en     = acc && (state != IDLE);
    assign cnt_last  = acc && (state == CNT) && (pk_idx == 2'd1);
    // Header restarts byte counting; the count field reuses the packer
    // for two bytes only, so it must be rewound before the first data byte.
    assign pk_clr    = (acc && (state == IDLE)) || cnt_last;
    assign last_word = (remaining == 16'd1);
    assign tail_end  = (tail_cnt == 8'(RELEASE_CYCLES - 1));

    assign busy      = (state != IDLE);
    assign cpu_rst   = rst || busy;
    // Gated by rst so an in-flight word is never committed in the reset cycle.
    assign wr_strobe = (state == WRITE) && !rst;
    assign port_on   = (state == WRITE) || (state == VERIFY);

    loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clr),
        .byte_en    (pk_en),
        .byte_in    (rx_data),
        .word       (pk_word),
        .word_next  (pk_next),
        .idx        (pk_idx),
        .word_valid (pk_valid)
    );

`ifdef LOADER_VERIFY_EN
    logic [7:0]  lat_cnt;
    logic        lat_end;
    logic [31:0] rd_sel;

    assign lat_end = (lat_cnt == 8'(RD_LAT - 1));
    assign rd_sel  = (tgt == TGT_INST) ? ic_rd2 : dc_rd2;
`else
    logic [31:0] unused_rd;
    assign unused_rd = ic_rd2 ^ dc_rd2 ^ 32'(RD_LAT);
`endif

    always_comb begin
        state_d = state;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc && is_hdr) state_d = ADDR;
            end
            ADDR: begin
                if (pk_valid) state_d = CNT;
            end
            CNT: begin
                if (cnt_last) begin
                    state_d = (pk_next[31:16] == 16'd0) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (pk_valid) state_d = WRITE;
            end
            WRITE: begin
`ifdef LOADER_VERIFY_EN
                state_d = VERIFY;
`else
                state_d = last_word ? TAIL : DATA;
`endif
            end
`ifdef LOADER_VERIFY_EN
            VERIFY: begin
                if (lat_end) state_d = last_word ? TAIL : DATA;
            end
`endif
            TAIL: begin
                if (tail_end) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ic_a2  = '0;
        ic_wd2 = '0;
        ic_we2 = '0;
        dc_a2  = '0;
        dc_wd2 = '0;
        dc_we2 = '0;
        if (port_on) begin
            if (tgt == TGT_INST) begin
                ic_a2  = addr;
                ic_wd2 = (state == WRITE) ? pk_word : 32'd0;
                ic_we2 = {4{wr_strobe}};
            end else begin
                dc_a2  = addr;
                dc_wd2 = (state == WRITE) ? pk_word : 32'd0;
                dc_we2 = {4{wr_strobe}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tgt       <= TGT_INST;
            addr      <= '0;
            remaining <= '0;
            tail_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_d;
            tail_cnt <= (state == TAIL) ? tail_cnt + 8'd1 : 8'd0;
            if (state == IDLE && acc) begin
                if (is_hdr) begin
                    tgt <= (rx_data == HDR_INST) ? TGT_INST : TGT_DATA;
                    err <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == ADDR && pk_valid) begin
                addr <= pk_next & 32'hFFFF_FFFC;
            end
            if (cnt_last) begin
                remaining <= pk_next[31:16];
            end
`ifdef LOADER_VERIFY_EN
            // Address advances only after read-back so VERIFY sees the written location.
            if (state == VERIFY && lat_end) begin
                if (rd_sel != pk_word) err <= 1'b1;
                addr      <= addr + 32'd4;
                remaining <= remaining - 16'd1;
            end
`else
            if (state == WRITE) begin
                addr      <= addr + 32'd4;
                remaining <= remaining - 16'd1;
            end
`endif
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == VERIFY) begin
            lat_cnt <= lat_cnt + 8'd1;
        end else begin
            lat_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_debug_mem_loader.sv
// Scoreboard bench for debug_mem_loader: directed frames, expected writes queued,
// a negedge monitor pops and compares every debug-port write strobe.
module tb_debug_mem_loader;

    localparam int R = 4;
`ifdef LOADER_VERIFY_EN
    localparam int VL = 1;
`else
    localparam int VL = 0;
`endif

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] ic_a2, ic_wd2, ic_rd2;
    logic [3:0]  ic_we2;
    logic [31:0] dc_a2, dc_wd2, dc_rd2;
    logic [3:0]  dc_we2;
    logic        cpu_rst, busy, done, err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    wr_t q[$];

    logic [31:0] ic_last = 32'd0;
    logic [31:0] dc_last = 32'd0;
    int          ic_wr_n = 0;
    int          corrupt_at = -1;

    debug_mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .ic_a2    (ic_a2),
        .ic_wd2   (ic_wd2),
        .ic_we2   (ic_we2),
        .ic_rd2   (ic_rd2),
        .dc_a2    (dc_a2),
        .dc_wd2   (dc_wd2),
        .dc_we2   (dc_we2),
        .dc_rd2   (dc_rd2),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ic_we2 != 4'h0) begin
            ic_last <= ic_wd2;
            ic_wr_n <= ic_wr_n + 1;
        end
        if (dc_we2 != 4'h0) dc_last <= dc_wd2;
    end

    // Read-back model: returns the last written word, optionally corrupted once.
    assign ic_rd2 = ic_last ^ ((ic_wr_n == corrupt_at) ? 32'hFFFF_0000 : 32'h0);
    assign dc_rd2 = dc_last;

    always @(negedge clk) begin
        if (ic_we2 != 4'h0 || dc_we2 != 4'h0) begin
            total++;
            if (ic_we2 != 4'h0 && dc_we2 != 4'h0) begin
                bad++;
                $display("FAIL both_ports: ic_we2=%h dc_we2=%h required one idle",
                         ic_we2, dc_we2);
            end
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: ic_we2=%h dc_we2=%h a2=%h/%h required none",
                         ic_we2, dc_we2, ic_a2, dc_a2);
            end else begin
                wr_t e;
                logic        gp;
                logic [31:0] ga, gd;
                logic [3:0]  gw;
                e  = q.pop_front();
                gp = (dc_we2 != 4'h0);
                ga = gp ? dc_a2 : ic_a2;
                gd = gp ? dc_wd2 : ic_wd2;
                gw = gp ? dc_we2 : ic_we2;
                if (gp !== e.port || ga !== e.a || gd !== e.d || gw !== 4'hF) begin
                    bad++;
                    $display("FAIL write: got port=%0d a=%h d=%h we=%h required port=%0d a=%h d=%h we=f",
                             gp, ga, gd, gw, e.port, e.a, e.d);
                end
            end
            last_wr_cyc = cyc;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic send_head(input logic [7:0] h, input logic [31:0] a, input logic [15:0] c);
        send(h);
        send_word(a);
        send(c[7:0]);
        send(c[15:8]);
    endtask

    task automatic exp_wr(input logic p, input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.port = p;
        e.a    = a;
        e.d    = d;
        q.push_back(e);
    endtask

    task automatic wait_done(input string nm, input bit had_wr);
        int n;
        int dc0;
        n = 0;
        dc0 = done_cnt;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        if (had_wr) chk({nm, "_tail_len"}, 32'(cyc - last_wr_cyc), 32'(R + VL));
        chk({nm, "_cpu_rst_tail"}, {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        chk({nm, "_done_width"}, {31'd0, done}, 32'd0);
        chk({nm, "_cpu_rst_rel"}, {31'd0, cpu_rst}, 32'd0);
        chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
        chk({nm, "_q_empty"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we", {24'd0, ic_we2, dc_we2}, 32'd0);
        chk("rst_ic_a2", ic_a2, 32'd0);
        chk("rst_dc_wd2", dc_wd2, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: two instruction words at 0
        exp_wr(1'b0, 32'h0000_0000, 32'h0000_0013);
        exp_wr(1'b0, 32'h0000_0004, 32'h0010_0093);
        send_head(8'hA5, 32'h0000_0000, 16'd2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_done("t1", 1'b1);
        chk("t1_err", {31'd0, err}, 32'd0);

        // 2: data cache, unaligned address forced to word alignment
        exp_wr(1'b1, 32'h0000_0100, 32'hEFBE_ADDE);
        send_head(8'h5A, 32'h0000_0103, 16'd1);
        send_word(32'hEFBE_ADDE);
        chk("t2_strobe_lat", {28'd0, dc_we2}, 32'h0000_000F);
        chk("t2_ic_idle", {28'd0, ic_we2}, 32'd0);
        wait_done("t2", 1'b1);

        // 3: bad header then empty frame
        send(8'h33);
        chk("t3_err_set", {31'd0, err}, 32'd1);
        chk("t3_stay_idle", {31'd0, busy}, 32'd0);
        chk("t3_idle_ready", {31'd0, rx_ready}, 32'd1);
        send_head(8'hA5, 32'h0000_0000, 16'd0);
        chk("t3_err_clr", {31'd0, err}, 32'd0);
        wait_done("t3", 1'b0);

        // 4: address wrap
        exp_wr(1'b0, 32'hFFFF_FFFC, 32'h1122_3344);
        exp_wr(1'b0, 32'h0000_0000, 32'h5566_7788);
        send_head(8'hA5, 32'hFFFF_FFFC, 16'd2);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        wait_done("t4", 1'b1);

        // 5: reset mid-frame, then a clean frame
        send_head(8'h5A, 32'h0000_0020, 16'd1);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        exp_wr(1'b1, 32'h0000_0040, 32'h0403_0201);
        send_head(8'h5A, 32'h0000_0040, 16'd1);
        send_word(32'h0403_0201);
        wait_done("t5", 1'b1);

`ifdef LOADER_VERIFY_EN
        // 6: first read-back corrupted, frame still completes
        corrupt_at = ic_wr_n + 1;
        exp_wr(1'b0, 32'h0000_0080, 32'h0A0B_0C0D);
        exp_wr(1'b0, 32'h0000_0084, 32'h0102_0304);
        send_head(8'hA5, 32'h0000_0080, 16'd2);
        send_word(32'h0A0B_0C0D);
        send_word(32'h0102_0304);
        wait_done("t6", 1'b1);
        chk("t6_err", {31'd0, err}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
